// File: rtl/nn_memory_arbiter_if.sv
// Bundle of requester-side and external-memory signals around nn_memory_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface nn_memory_arbiter_if #(
  parameter int NUM_CHANNELS = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32
);
  logic [NUM_CHANNELS-1:0]            ch_req;
  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] ch_addr;
  logic [NUM_CHANNELS-1:0]            ch_rw;
  logic [NUM_CHANNELS-1:0]            ch_bw;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_wdata;
  logic [NUM_CHANNELS-1:0]            ch_wait;
  logic [DATA_WIDTH-1:0]              ch_rdata;
  logic [NUM_CHANNELS-1:0]            ch_err;
  logic [ADDR_WIDTH-1:0]              mem_addr;
  logic [DATA_WIDTH-1:0]              mem_wdata;
  logic                               mem_wdata_oe;
  logic [DATA_WIDTH-1:0]              mem_rdata;
  logic                               mem_enable;
  logic                               mem_rw;
  logic                               mem_bw;
  logic                               nMemoryWait;

  modport slave (
    input  ch_req, ch_addr, ch_rw, ch_bw, ch_wdata, mem_rdata, nMemoryWait,
    output ch_wait, ch_rdata, ch_err, mem_addr, mem_wdata, mem_wdata_oe,
           mem_enable, mem_rw, mem_bw
  );

  modport master (
    output ch_req, ch_addr, ch_rw, ch_bw, ch_wdata, mem_rdata, nMemoryWait,
    input  ch_wait, ch_rdata, ch_err, mem_addr, mem_wdata, mem_wdata_oe,
           mem_enable, mem_rw, mem_bw
  );
endinterface

// File: rtl/nn_memory_arbiter.sv
// N-channel arbiter merging cache-controller requests onto one external memory
// port, with round-robin or fixed-priority grant and a per-transaction timeout.
//
// state | meaning
// IDLE  | arbitrate pending requests, latch the winner's command
// ISSUE | first request cycle, nMemoryWait ignored
// WAIT  | hold command until memory ready or timeout
// DONE  | release granted requester for one cycle
module nn_memory_arbiter #(
  parameter int NUM_CHANNELS   = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clock,
  input  logic                reset,
  nn_memory_arbiter_if.slave  bus
);

  localparam int CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TLOAD = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           grant;
  logic [CW-1:0]           ptr;
  logic [CW-1:0]           pick;
  logic [CW-1:0]           cand;
  logic                    found;
  logic                    any_req;
  logic [TW-1:0]           tmo_cnt;
  logic [NUM_CHANNELS-1:0] done_mask;

  function automatic logic [CW-1:0] rr_index(input logic [CW-1:0] base, input int off);
    int s;
    s = int'(base) + 1 + off;
    return CW'(s % NUM_CHANNELS);
  endfunction

  // Round-robin starts one past the last winner; fixed priority scans from 0.
  always_comb begin
    pick    = '0;
    cand    = '0;
    found   = 1'b0;
    any_req = |bus.ch_req;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      cand = (PRIORITY_MODE != 0) ? CW'(i) : rr_index(ptr, i);
      if (!found && bus.ch_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    done_mask = '0;
    if (state == DONE && !reset)
      done_mask[grant] = 1'b1;
  end

  assign bus.ch_wait = bus.ch_req & ~done_mask;

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      grant            <= '0;
      ptr              <= CW'(NUM_CHANNELS - 1);
      tmo_cnt          <= '0;
      bus.mem_enable   <= 1'b0;
      bus.mem_rw       <= 1'b1;
      bus.mem_bw       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.mem_wdata_oe <= 1'b0;
      bus.ch_rdata     <= '0;
      bus.ch_err       <= '0;
    end else begin
      bus.ch_err <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant            <= pick;
            bus.mem_addr     <= bus.ch_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
            bus.mem_wdata    <= bus.ch_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
            bus.mem_rw       <= bus.ch_rw[pick];
            bus.mem_bw       <= bus.ch_bw[pick];
            bus.mem_enable   <= 1'b1;
            bus.mem_wdata_oe <= ~bus.ch_rw[pick];
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= TW'(TLOAD);
          state   <= WAIT;
        end
        WAIT: begin
          if (bus.nMemoryWait) begin
            if (bus.mem_rw)
              bus.ch_rdata <= bus.mem_rdata;
            bus.mem_enable   <= 1'b0;
            bus.mem_wdata_oe <= 1'b0;
            state            <= DONE;
          end else if (TIMEOUT_CYCLES != 0 && tmo_cnt == '0) begin
            // Abort: error pulse lines up with the DONE cycle.
            bus.mem_enable    <= 1'b0;
            bus.mem_wdata_oe  <= 1'b0;
            bus.ch_err[grant] <= 1'b1;
            state             <= DONE;
          end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        DONE: begin
          ptr   <= grant;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nn_memory_arbiter.md
Name: nn_memory_arbiter

Overview:
- Parametrised N-channel arbiter that merges the processor's memory requesters onto one external memory port; by default these are the instruction cache controller and the data cache controller.
- It sits between the cache controllers and the single external MemoryController.
- Adds round-robin or fixed-priority arbitration, a per-transaction timeout with error reporting, and generalised address/data widths.

Parameters:
NUM_CHANNELS, 2, number of requesters (1..8); channel 0 = instruction, 1 = data.
ADDR_WIDTH, 32, address width.
DATA_WIDTH, 32, data width.
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
TIMEOUT_CYCLES, 64, WAIT-state cycles before abort; 0 disables the timeout.

Ports:
- clock  in  1  single system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- ch_req  in  NUM_CHANNELS  per-channel request, held until the channel's wait drops.
- ch_addr  in  NUM_CHANNELS*ADDR_WIDTH  packed addresses; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- ch_rw  in  NUM_CHANNELS  1 = read, 0 = write.
- ch_bw  in  NUM_CHANNELS  1 = byte, 0 = word.
- ch_wdata  in  NUM_CHANNELS*DATA_WIDTH  packed write data.
- ch_wait  out  NUM_CHANNELS  1 = stall requester.
- ch_rdata  out  DATA_WIDTH  shared read data, valid while the completing channel's wait is low.
- ch_err  out  NUM_CHANNELS  one-cycle timeout-abort pulse.
- mem_addr  out  ADDR_WIDTH  external address.
- mem_wdata  out  DATA_WIDTH  external write data.
- mem_wdata_oe  out  1  drive enable for the external bidirectional bus on writes.
- mem_rdata  in  DATA_WIDTH  external read data.
- mem_enable  out  1  1 = memory request.
- mem_rw  out  1  1 = read, 0 = write.
- mem_bw  out  1  1 = byte, 0 = word.
- nMemoryWait  in  1  0 = memory busy; ignored in the first request cycle.

Behaviour:
- Reset values:
  - state = IDLE; mem_enable = 0; mem_rw = 1; mem_bw = 0; mem_addr = 0; mem_wdata = 0; mem_wdata_oe = 0.
  - ch_rdata = 0; ch_err = 0; round-robin pointer = NUM_CHANNELS-1, so channel 0 has first priority.
  - ch_wait is combinational: ch_wait[i] = ch_req[i] & ~(state==DONE & grant==i). During reset it therefore equals ch_req.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any ch_req bit is set, choose grant, latch that channel's addr/rw/bw/wdata into the mem_* registers, and go to ISSUE.
  - Round-robin: search from pointer+1 upward, wrapping modulo NUM_CHANNELS.
  - Fixed priority: choose the lowest set index.
  - If no request, stay in IDLE.
- ISSUE (exactly 1 cycle): mem_enable = 1; mem_wdata_oe = ~mem_rw; nMemoryWait is ignored; go to WAIT and clear the timeout counter.
- WAIT:
  - mem_enable and mem_* outputs are held stable.
  - nMemoryWait = 1: capture mem_rdata into ch_rdata (reads only; writes leave ch_rdata unchanged), deassert mem_enable and mem_wdata_oe, go to DONE.
  - Otherwise increment the timeout counter. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1, abort: deassert mem_enable, pulse ch_err[grant] in the next cycle, and go to DONE.
- DONE (exactly 1 cycle):
  - ch_wait[grant] = 0; ch_rdata is valid.
  - Update pointer = grant; go to IDLE.
- Latency: best case, a request seen in IDLE at cycle 0 completes with wait low at cycle 3. Each additional memory wait cycle adds 1.
- Requester rule: a channel that still has ch_req high in the cycle after DONE is treated as issuing a new request.
- Non-granted channels keep ch_wait high for the whole transaction.
- A request raised during ISSUE, WAIT or DONE is not arbitrated until the next IDLE.
- Changes to a granted channel's inputs after IDLE are ignored; inputs are latched.
- If the granted channel drops ch_req mid-transaction, the transaction still completes and DONE is still visited.
- Reset asserted in any state returns all outputs to their reset values on the next edge and drops the pending transaction; no ch_err is raised.
- Round-robin guarantees no channel waits more than NUM_CHANNELS-1 transactions.

Test Plan:
- Single read: ch_req=01, ch_addr[0]=0x100, rw=1; memory returns 0xDEADBEEF with nMemoryWait=1 immediately -> mem_enable high in cycles 1-2, ch_wait[0] low in cycle 3, ch_rdata=0xDEADBEEF.
- Write with waits: channel 1 writes 0x55AA to 0x2000 with nMemoryWait=0 for 3 WAIT cycles -> mem_wdata_oe=1 through WAIT, ch_wait[1] low in cycle 6, ch_rdata unchanged.
- Contention, round-robin: both channels request continuously -> grants alternate 0,1,0,1; in fixed-priority mode channel 0 always wins.
- Timeout: TIMEOUT_CYCLES=4, nMemoryWait held 0 -> ch_err[grant] pulses once, ch_wait drops for one cycle, FSM returns to IDLE.
- Reset in WAIT: reset asserted mid-transaction -> next cycle mem_enable=0, state IDLE, ch_err=0; pointer back to NUM_CHANNELS-1 (channel 0 wins next).
